ex_mem_stage: RTL and testbench
===============================

Name: ex_mem_stage

Overview:
- Pipeline stage directly downstream of the ALU: consumes the ALU result and flags (isNotEqual, isLessThan, overflow) for the instruction in execute.
- Resolves branches and jumps and substitutes rstatus writes when overflow occurs.
- Squashes wrong-path instructions for a fixed number of pipeline advances after a redirect.
- Registers everything into the execute/memory pipeline latch under stall and flush control.

Parameters:
- SQUASH_DEPTH, 2, number of pipeline advances converted to bubbles after a taken redirect (fetch plus decode). Legal range 1..7.

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- stall  in  1  hold: all state frozen
- flush  in  1  kill: the latch becomes a bubble and the squash count clears
- in_valid  in  1  execute slot holds a real instruction
- in_pc  in  32  PC of the execute instruction
- in_insn_op  in  5  instruction opcode field
- in_alu_op  in  5  ALU opcode driven to the ALU
- in_rd  in  5  destination register
- in_target  in  32  precomputed target (pc+1+N, T, or $rd for jr); setx immediate
- in_store_data  in  32  rd value for sw
- alu_result  in  32  ALU data_result
- alu_ne  in  1  ALU isNotEqual
- alu_lt  in  1  ALU isLessThan
- alu_ovf  in  1  ALU overflow
- out_valid  out  1  latch holds a real instruction
- out_result  out  32  writeback value, or address for lw/sw
- out_rd  out  5  writeback register
- out_wren  out  1  register-file write enable
- out_mem_we  out  1  store
- out_mem_re  out  1  load
- out_store_data  out  32  store data
- redirect  out  1  one-cycle pulse: fetch must load redirect_pc
- redirect_pc  out  32  redirect target
- squash_active  out  1  squash count is nonzero

Behaviour:
- Reset (reset=0, asynchronous): every output goes to 0 and the squash count goes to 0.
- Opcodes: R-type 00000, j 00001, bne 00010, jal 00011, jr 00100, addi 00101, blt 00110, sw 00111, lw 01000, setx 10101. Any other opcode is a NOP: valid, no write.
- Advance means stall=0.
- Accept means advance, in_valid=1, squash count 0 and flush=0. Latency is 1 cycle from accept to out_*.
- Priority is flush > stall > normal.
- Flush (in any cycle, stall ignored):
  - out_valid, out_wren, out_mem_we and out_mem_re go to 0.
  - The squash count goes to 0.
  - redirect goes to 0.
- Stall: all registers hold; redirect is 0 during stall cycles. A redirect already issued is never repeated.
- Advance without accept: the latch is loaded as a bubble (all controls 0). If the squash count is >0 it decrements, whether or not in_valid is set.
- Taken condition on accept:
  - bne: alu_ne=1.
  - blt: alu_lt=1.
  - j, jal, jr: always taken.
- Taken on accept: the next cycle has redirect=1 and redirect_pc=in_target, and the squash count loads SQUASH_DEPTH. A taken instruction itself still commits: jal writes.
- Writeback on accept:
  - R-type and addi: out_result=alu_result, out_rd=in_rd, out_wren=(in_rd!=0).
  - lw: out_result=alu_result (address), out_mem_re=1, out_rd=in_rd, out_wren=(in_rd!=0).
  - sw: out_mem_we=1, out_store_data=in_store_data, out_wren=0.
  - jal: out_rd=31, out_result=in_pc+1 (32-bit wrap), out_wren=1.
  - setx: out_rd=30, out_result=in_target, out_wren=1.
  - bne, blt, j, jr: out_wren=0.
- Overflow substitution (takes precedence over normal writeback): out_rd=30, out_wren=1.
  - R-type with alu_op 00000 (add) and alu_ovf: out_result=1.
  - addi with alu_ovf: out_result=2.
  - R-type with alu_op 00001 (sub) and alu_ovf: out_result=3.
  - alu_ovf is ignored for all other opcodes.
- Squash count is a saturating down-counter of width 3 that never underflows. squash_active=(count!=0).
- Reset released mid-stream: the first accept is possible on the first advance cycle after release.

Decomposition:
- Shared package (proc_pkg):
  - opcode constants: OP_RTYPE, OP_J, OP_BNE, OP_JAL, OP_JR, OP_ADDI, OP_BLT, OP_SW, OP_LW, OP_SETX
  - ALU opcodes: ALU_ADD, ALU_SUB
  - RSTATUS_ADD=1, RSTATUS_ADDI=2, RSTATUS_SUB=3
  - register indices: REG_RSTATUS=30, REG_RA=31
- One sub-module, squash_ctr: load, advance and clear inputs; count and active outputs.

Test Plan:
- add with alu_result=0x00000005, in_rd=4, no overflow -> next cycle out_valid=1, out_rd=4, out_result=5, out_wren=1.
- addi with alu_ovf=1, in_rd=7 -> out_rd=30, out_result=2, out_wren=1. sub (alu_op 00001) with alu_ovf=1 -> out_result=3.
- bne with alu_ne=1, in_target=0x40, then valid instructions on the next 3 cycles -> redirect=1 for exactly one cycle with redirect_pc=0x40; the next 2 latches are bubbles; the third instruction commits.
- jal at in_pc=0x10, in_target=0x80 -> out_rd=31, out_result=0x11, out_wren=1, redirect_pc=0x80. Assert stall for 3 cycles during the squash window -> the count stays at its value; redirect is not re-pulsed.
- flush together with stall while out_valid=1 and squash count=2 -> next cycle out_valid=0 and squash_active=0.
- reset driven low mid-stream, asynchronously between clock edges -> all outputs are 0 immediately. sw accepted after release -> out_mem_we=1, out_wren=0, out_store_data=in_store_data.

Source files
------------

// File: rtl/proc_pkg.sv
// Shared opcode, ALU-op and register constants for the execute/memory path,
// plus the rstatus code lookup used for overflow substitution.
package proc_pkg;

  localparam logic [4:0] OP_RTYPE = 5'b00000;
  localparam logic [4:0] OP_J     = 5'b00001;
  localparam logic [4:0] OP_BNE   = 5'b00010;
  localparam logic [4:0] OP_JAL   = 5'b00011;
  localparam logic [4:0] OP_JR    = 5'b00100;
  localparam logic [4:0] OP_ADDI  = 5'b00101;
  localparam logic [4:0] OP_BLT   = 5'b00110;
  localparam logic [4:0] OP_SW    = 5'b00111;
  localparam logic [4:0] OP_LW    = 5'b01000;
  localparam logic [4:0] OP_SETX  = 5'b10101;

  localparam logic [4:0] ALU_ADD = 5'b00000;
  localparam logic [4:0] ALU_SUB = 5'b00001;

  localparam logic [31:0] RSTATUS_ADD  = 32'd1;
  localparam logic [31:0] RSTATUS_ADDI = 32'd2;
  localparam logic [31:0] RSTATUS_SUB  = 32'd3;

  localparam logic [4:0] REG_RSTATUS = 5'd30;
  localparam logic [4:0] REG_RA      = 5'd31;

  typedef struct packed {
    logic [31:0] result;
    logic [4:0]  rd;
    logic        wren;
    logic        mem_we;
    logic        mem_re;
  } wb_t;

  // Zero means the instruction has no overflow-reporting form.
  function automatic logic [31:0] rstatus_code(input logic [4:0] insn_op,
                                               input logic [4:0] alu_op);
    if (insn_op == OP_RTYPE && alu_op == ALU_ADD) return RSTATUS_ADD;
    if (insn_op == OP_RTYPE && alu_op == ALU_SUB) return RSTATUS_SUB;
    if (insn_op == OP_ADDI) return RSTATUS_ADDI;
    return 32'd0;
  endfunction

endpackage

// File: rtl/ex_mem_stage_squash_ctr.sv
// Wrong-path squash counter: loads DEPTH on a taken redirect, counts down
// once per pipeline advance, never underflows, cleared by flush.
module squash_ctr #(
  parameter int DEPTH = 2
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       load,
  input  logic       advance,
  input  logic       clear,
  output logic [2:0] count,
  output logic       active
);

  logic [2:0] count_reg;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count_reg <= 3'd0;
    end else if (clear) begin
      count_reg <= 3'd0;
    end else if (advance) begin
      if (load)
        count_reg <= 3'(DEPTH);
      else if (count_reg != 3'd0)
        count_reg <= count_reg - 3'd1;
    end
  end

  assign count  = count_reg;
  assign active = (count_reg != 3'd0);

endmodule

// File: rtl/ex_mem_stage.sv
// Execute/memory pipeline latch: resolves branches and jumps, substitutes
// rstatus writes on ALU overflow, and squashes wrong-path instructions.
module ex_mem_stage
  import proc_pkg::*;
#(
  parameter int SQUASH_DEPTH = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        stall,
  input  logic        flush,
  input  logic        in_valid,
  input  logic [31:0] in_pc,
  input  logic [4:0]  in_insn_op,
  input  logic [4:0]  in_alu_op,
  input  logic [4:0]  in_rd,
  input  logic [31:0] in_target,
  input  logic [31:0] in_store_data,
  input  logic [31:0] alu_result,
  input  logic        alu_ne,
  input  logic        alu_lt,
  input  logic        alu_ovf,
  output logic        out_valid,
  output logic [31:0] out_result,
  output logic [4:0]  out_rd,
  output logic        out_wren,
  output logic        out_mem_we,
  output logic        out_mem_re,
  output logic [31:0] out_store_data,
  output logic        redirect,
  output logic [31:0] redirect_pc,
  output logic        squash_active
);

  logic        advance;
  logic        accept;
  logic        taken;
  logic [2:0]  squash_count;
  logic [31:0] ovf_code;
  wb_t         wb;

  assign advance = !stall;
  assign accept  = advance && in_valid && (squash_count == 3'd0) && !flush;

  always_comb begin
    taken = 1'b0;
    case (in_insn_op)
      OP_BNE:              taken = alu_ne;
      OP_BLT:              taken = alu_lt;
      OP_J, OP_JAL, OP_JR: taken = 1'b1;
      default:             taken = 1'b0;
    endcase
  end

  assign ovf_code = rstatus_code(in_insn_op, in_alu_op);

  always_comb begin
    wb = '{result: alu_result, rd: in_rd, wren: 1'b0, mem_we: 1'b0, mem_re: 1'b0};
    case (in_insn_op)
      OP_RTYPE, OP_ADDI: wb.wren = (in_rd != 5'd0);
      OP_LW: begin
        wb.mem_re = 1'b1;
        wb.wren   = (in_rd != 5'd0);
      end
      OP_SW:  wb.mem_we = 1'b1;
      OP_JAL: begin
        wb.rd     = REG_RA;
        wb.result = in_pc + 32'd1;
        wb.wren   = 1'b1;
      end
      OP_SETX: begin
        wb.rd     = REG_RSTATUS;
        wb.result = in_target;
        wb.wren   = 1'b1;
      end
      default: ;
    endcase
    // Overflow on an arithmetic op reports into rstatus instead of rd.
    if (alu_ovf && ovf_code != 32'd0) begin
      wb.rd     = REG_RSTATUS;
      wb.result = ovf_code;
      wb.wren   = 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      out_valid      <= 1'b0;
      out_result     <= 32'd0;
      out_rd         <= 5'd0;
      out_wren       <= 1'b0;
      out_mem_we     <= 1'b0;
      out_mem_re     <= 1'b0;
      out_store_data <= 32'd0;
      redirect       <= 1'b0;
      redirect_pc    <= 32'd0;
    end else if (flush) begin
      out_valid  <= 1'b0;
      out_wren   <= 1'b0;
      out_mem_we <= 1'b0;
      out_mem_re <= 1'b0;
      redirect   <= 1'b0;
    end else if (stall) begin
      redirect <= 1'b0;
    end else begin
      out_valid  <= accept;
      out_wren   <= accept && wb.wren;
      out_mem_we <= accept && wb.mem_we;
      out_mem_re <= accept && wb.mem_re;
      redirect   <= accept && taken;
      if (accept) begin
        out_result     <= wb.result;
        out_rd         <= wb.rd;
        out_store_data <= in_store_data;
      end
      if (accept && taken)
        redirect_pc <= in_target;
    end
  end

  squash_ctr #(.DEPTH(SQUASH_DEPTH)) u_squash_ctr (
    .clock   (clock),
    .reset   (reset),
    .load    (accept && taken),
    .advance (advance),
    .clear   (flush),
    .count   (squash_count),
    .active  (squash_active)
  );

endmodule

// File: tb/tb_ex_mem_stage.sv
// Scoreboard bench for ex_mem_stage: each driven cycle pushes its expected
// latch contents, popped and compared one clock later.
module tb_ex_mem_stage;
  import proc_pkg::*;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        stall = 1'b0, flush = 1'b0, in_valid = 1'b0;
  logic [31:0] in_pc = '0, in_target = '0, in_store_data = '0, alu_result = '0;
  logic [4:0]  in_insn_op = '0, in_alu_op = '0, in_rd = '0;
  logic        alu_ne = 1'b0, alu_lt = 1'b0, alu_ovf = 1'b0;
  logic        out_valid, out_wren, out_mem_we, out_mem_re, redirect, squash_active;
  logic [31:0] out_result, out_store_data, redirect_pc;
  logic [4:0]  out_rd;

  ex_mem_stage #(.SQUASH_DEPTH(2)) dut (
    .clock(clock), .reset(reset), .stall(stall), .flush(flush),
    .in_valid(in_valid), .in_pc(in_pc), .in_insn_op(in_insn_op),
    .in_alu_op(in_alu_op), .in_rd(in_rd), .in_target(in_target),
    .in_store_data(in_store_data), .alu_result(alu_result),
    .alu_ne(alu_ne), .alu_lt(alu_lt), .alu_ovf(alu_ovf),
    .out_valid(out_valid), .out_result(out_result), .out_rd(out_rd),
    .out_wren(out_wren), .out_mem_we(out_mem_we), .out_mem_re(out_mem_re),
    .out_store_data(out_store_data), .redirect(redirect),
    .redirect_pc(redirect_pc), .squash_active(squash_active)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        valid;
    logic [4:0]  rd;
    logic [31:0] result;
    logic        wren, we, re;
    logic [31:0] sd;
    logic        redir;
    logic [31:0] rpc;
    logic        sq;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic exp_t ex(input logic v, input logic [4:0] rd, input logic [31:0] res,
                              input logic wren, input logic we, input logic re,
                              input logic [31:0] sd, input logic redir,
                              input logic [31:0] rpc, input logic sq);
    exp_t e;
    e.valid = v; e.rd = rd; e.result = res; e.wren = wren; e.we = we; e.re = re;
    e.sd = sd; e.redir = redir; e.rpc = rpc; e.sq = sq;
    return e;
  endfunction

  function automatic exp_t bubble(input logic sq);
    return ex(1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, sq);
  endfunction

  task automatic drv(input logic v, input logic [4:0] op, input logic [4:0] aop,
                     input logic [4:0] rd, input logic [31:0] pc, input logic [31:0] tgt,
                     input logic [31:0] sd, input logic [31:0] res,
                     input logic ne, input logic lt, input logic ovf);
    in_valid = v; in_insn_op = op; in_alu_op = aop; in_rd = rd; in_pc = pc;
    in_target = tgt; in_store_data = sd; alu_result = res;
    alu_ne = ne; alu_lt = lt; alu_ovf = ovf;
  endtask

  task automatic cyc(input string tag, input exp_t e);
    exp_t x;
    sb.push_back(e);
    @(posedge clock);
    #1;
    x = sb.pop_front();
    $display("txn %s valid=%0b rd=%0d result=%h wren=%0b we=%0b re=%0b redirect=%0b pc=%h sq=%0b",
             tag, out_valid, out_rd, out_result, out_wren, out_mem_we, out_mem_re,
             redirect, redirect_pc, squash_active);
    check({tag, ".valid"}, 32'(out_valid), 32'(x.valid));
    check({tag, ".wren"}, 32'(out_wren), 32'(x.wren));
    check({tag, ".mem_we"}, 32'(out_mem_we), 32'(x.we));
    check({tag, ".mem_re"}, 32'(out_mem_re), 32'(x.re));
    check({tag, ".redirect"}, 32'(redirect), 32'(x.redir));
    check({tag, ".squash"}, 32'(squash_active), 32'(x.sq));
    if (x.wren) begin
      check({tag, ".rd"}, 32'(out_rd), 32'(x.rd));
      check({tag, ".result"}, out_result, x.result);
    end
    if (x.we) check({tag, ".store_data"}, out_store_data, x.sd);
    if (x.redir) check({tag, ".redirect_pc"}, redirect_pc, x.rpc);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".valid"}, 32'(out_valid), 32'd0);
    check({tag, ".result"}, out_result, 32'd0);
    check({tag, ".rd"}, 32'(out_rd), 32'd0);
    check({tag, ".wren"}, 32'(out_wren), 32'd0);
    check({tag, ".mem_we"}, 32'(out_mem_we), 32'd0);
    check({tag, ".mem_re"}, 32'(out_mem_re), 32'd0);
    check({tag, ".store_data"}, out_store_data, 32'd0);
    check({tag, ".redirect"}, 32'(redirect), 32'd0);
    check({tag, ".redirect_pc"}, redirect_pc, 32'd0);
    check({tag, ".squash"}, 32'(squash_active), 32'd0);
  endtask

  initial begin
    #12;
    check_all_zero("reset");
    reset = 1'b1;

    drv(1, OP_RTYPE, ALU_ADD, 5'd4, 32'h0, 32'h0, 32'h0, 32'h5, 0, 0, 0);
    cyc("add", ex(1, 5'd4, 32'h5, 1, 0, 0, 0, 0, 0, 0));
    drv(1, OP_ADDI, ALU_ADD, 5'd7, 32'h0, 32'h0, 32'h0, 32'h8000_0000, 0, 0, 1);
    cyc("addi_ovf", ex(1, 5'd30, 32'd2, 1, 0, 0, 0, 0, 0, 0));
    drv(1, OP_RTYPE, ALU_SUB, 5'd9, 32'h0, 32'h0, 32'h0, 32'h7fff_ffff, 0, 0, 1);
    cyc("sub_ovf", ex(1, 5'd30, 32'd3, 1, 0, 0, 0, 0, 0, 0));
    drv(1, OP_RTYPE, ALU_ADD, 5'd9, 32'h0, 32'h0, 32'h0, 32'h7fff_ffff, 0, 0, 1);
    cyc("add_ovf", ex(1, 5'd30, 32'd1, 1, 0, 0, 0, 0, 0, 0));
    drv(1, OP_RTYPE, ALU_ADD, 5'd0, 32'h0, 32'h0, 32'h0, 32'h77, 0, 0, 0);
    cyc("add_r0", ex(1, 5'd0, 32'h0, 0, 0, 0, 0, 0, 0, 0));
    drv(1, OP_LW, ALU_ADD, 5'd9, 32'h0, 32'h0, 32'h0, 32'h100, 0, 0, 1);
    cyc("lw", ex(1, 5'd9, 32'h100, 1, 0, 1, 0, 0, 0, 0));
    drv(1, OP_SETX, ALU_ADD, 5'd2, 32'h0, 32'h1234, 32'h0, 32'h0, 0, 0, 0);
    cyc("setx", ex(1, 5'd30, 32'h1234, 1, 0, 0, 0, 0, 0, 0));
    drv(1, 5'b01111, ALU_ADD, 5'd3, 32'h0, 32'h0, 32'h0, 32'h1, 0, 0, 0);
    cyc("nop", ex(1, 5'd0, 32'h0, 0, 0, 0, 0, 0, 0, 0));
    drv(1, OP_BNE, ALU_SUB, 5'd0, 32'h20, 32'h99, 32'h0, 32'h0, 0, 0, 0);
    cyc("bne_nt", ex(1, 5'd0, 32'h0, 0, 0, 0, 0, 0, 0, 0));

    // Taken bne: two wrong-path instructions squashed, third commits.
    drv(1, OP_BNE, ALU_SUB, 5'd0, 32'h20, 32'h40, 32'h0, 32'h0, 1, 0, 0);
    cyc("bne_t", ex(1, 5'd0, 32'h0, 0, 0, 0, 0, 1, 32'h40, 1));
    drv(1, OP_RTYPE, ALU_ADD, 5'd5, 32'h21, 32'h0, 32'h0, 32'h7, 0, 0, 0);
    cyc("sq1", bubble(1));
    drv(1, OP_RTYPE, ALU_ADD, 5'd6, 32'h22, 32'h0, 32'h0, 32'h7, 0, 0, 0);
    cyc("sq2", bubble(0));
    drv(1, OP_RTYPE, ALU_ADD, 5'd8, 32'h40, 32'h0, 32'h0, 32'h9, 0, 0, 0);
    cyc("after_bne", ex(1, 5'd8, 32'h9, 1, 0, 0, 0, 0, 0, 0));

    // jal, then a 3-cycle stall inside the squash window.
    drv(1, OP_JAL, ALU_ADD, 5'd1, 32'h10, 32'h80, 32'h0, 32'h0, 0, 0, 0);
    cyc("jal", ex(1, 5'd31, 32'h11, 1, 0, 0, 0, 1, 32'h80, 1));
    stall = 1'b1;
    drv(1, OP_RTYPE, ALU_ADD, 5'd5, 32'h11, 32'h0, 32'h0, 32'h7, 0, 0, 0);
    for (int i = 0; i < 3; i++)
      cyc("stall", ex(1, 5'd31, 32'h11, 1, 0, 0, 0, 0, 0, 1));
    stall = 1'b0;
    cyc("jal_sq1", bubble(1));
    cyc("jal_sq2", bubble(0));

    // Flush together with stall in the middle of a squash window.
    drv(1, OP_JAL, ALU_ADD, 5'd1, 32'h30, 32'h90, 32'h0, 32'h0, 0, 0, 0);
    cyc("jal2", ex(1, 5'd31, 32'h31, 1, 0, 0, 0, 1, 32'h90, 1));
    stall = 1'b1; flush = 1'b1;
    cyc("flush", bubble(0));
    stall = 1'b0; flush = 1'b0;
    drv(1, OP_RTYPE, ALU_ADD, 5'd12, 32'h90, 32'h0, 32'h0, 32'hab, 0, 0, 0);
    cyc("post_flush", ex(1, 5'd12, 32'hab, 1, 0, 0, 0, 0, 0, 0));

    drv(1, OP_BLT, ALU_SUB, 5'd0, 32'h50, 32'h200, 32'h0, 32'h0, 0, 1, 0);
    cyc("blt_t", ex(1, 5'd0, 32'h0, 0, 0, 0, 0, 1, 32'h200, 1));
    drv(0, OP_RTYPE, ALU_ADD, 5'd0, 32'h0, 32'h0, 32'h0, 32'h0, 0, 0, 0);
    cyc("blt_sq1", bubble(1));
    cyc("blt_sq2", bubble(0));
    drv(1, OP_JR, ALU_ADD, 5'd0, 32'h200, 32'h300, 32'h0, 32'h0, 0, 0, 0);
    cyc("jr", ex(1, 5'd0, 32'h0, 0, 0, 0, 0, 1, 32'h300, 1));

    // Asynchronous reset between clock edges, then a store after release.
    #2 reset = 1'b0;
    #1 check_all_zero("async_reset");
    #2 reset = 1'b1;
    drv(1, OP_SW, ALU_ADD, 5'd3, 32'h300, 32'h0, 32'hdead_beef, 32'h44, 0, 0, 0);
    cyc("sw", ex(1, 5'd0, 32'h0, 0, 1, 0, 32'hdead_beef, 0, 0, 0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
